// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode-side
// instruction queue head.
//   master (fetch_unit): drives imem_req/imem_addr and ir_valid/ir_data/ir_pc,
//                        receives imem_ack/imem_data and ir_ready.
//   slave  (memory + decode): the reverse directions.
interface fetch_unit_if #(
    parameter int unsigned IW = 16,
    parameter int unsigned AW = 9
) ();
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_data;
    logic          ir_valid;
    logic [IW-1:0] ir_data;
    logic [AW-1:0] ir_pc;
    logic          ir_ready;

    modport master (
        output imem_req, imem_addr, ir_valid, ir_data, ir_pc,
        input  imem_ack, imem_data, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir_data, ir_pc,
        output imem_ack, imem_data, ir_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Reads the active PC, issues a req/ack read to
// instruction memory and queues returned instructions (with their address)
// for decode. Pulses pc_inc once per accepted fetch; redirects flush the
// queue and discard any in-flight read.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   pc_in        - active PC from the PC bank
//   pc_err       - PC bank error flag; stops fetch
//   redirect     - control is rewriting the PC this cycle
//   pc_inc       - combinational increment request to the PC bank
//   fetch_halted - fetch stopped because of pc_err
//   bus          - imem read port and decode valid/ready head (fetch_unit_if.master)
// Build option: define FETCH_SKID_EN for a two-entry queue (default one entry).
module fetch_unit #(
    parameter int unsigned IW = 16,
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_err,
    input  logic          redirect,
    output logic          pc_inc,
    output logic          fetch_halted,
    fetch_unit_if.master  bus
);

`ifdef FETCH_SKID_EN
    localparam int unsigned D = 2;
`else
    localparam int unsigned D = 1;
`endif

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;

    state_t            state, state_next;
    entry_t [D-1:0]    q, q_next;
    logic   [D-1:0]    v, v_next;
    logic              err_pend, err_pend_next;
    logic              req_next, halted_next, load_addr;
    logic              push, pop, can_issue, halt_go, placed;

    // Queue is kept compacted toward index 0; entry 0 is the head.
    assign pop          = v[0] && bus.ir_ready;
    assign can_issue    = !v[D-1] || pop;
    assign halt_go      = pc_err || err_pend;
    assign push         = (state == REQ) && bus.imem_ack && !redirect;
    assign pc_inc       = rst_n && push;
    assign bus.ir_valid = v[0];
    assign bus.ir_data  = q[0].instr;
    assign bus.ir_pc    = q[0].pc;

    // Next-state and registered-output values.
    always_comb begin
        state_next    = state;
        err_pend_next = err_pend;
        load_addr     = 1'b0;
        case (state)
            IDLE: begin
                if (pc_err) begin
                    state_next = HALT;
                end else if (!redirect && can_issue) begin
                    state_next = REQ;
                    load_addr  = 1'b1;
                end
            end
            REQ: begin
                if (pc_err) err_pend_next = 1'b1;
                if (bus.imem_ack) begin
                    state_next = halt_go ? HALT : IDLE;
                end else if (redirect) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Memory reads cannot be aborted; wait out the ack and drop it.
                if (pc_err) err_pend_next = 1'b1;
                if (bus.imem_ack) state_next = halt_go ? HALT : IDLE;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // An error noticed mid-transaction only matters until that transaction ends.
        if (state_next != REQ && state_next != DRAIN) err_pend_next = 1'b0;
        req_next    = (state_next == REQ) || (state_next == DRAIN);
        halted_next = (state_next == HALT);
    end

    // Queue update: pop shifts down, push fills the lowest free slot, redirect flushes.
    always_comb begin
        q_next = q;
        v_next = v;
        placed = 1'b0;
        if (pop) begin
            for (int i = 0; i < int'(D) - 1; i++) begin
                q_next[i] = q[i + 1];
            end
            v_next = v >> 1;
        end
        if (push) begin
            for (int i = 0; i < int'(D); i++) begin
                if (!v_next[i] && !placed) begin
                    q_next[i].instr = bus.imem_data;
                    q_next[i].pc    = bus.imem_addr;
                    v_next[i]       = 1'b1;
                    placed          = 1'b1;
                end
            end
        end
        if (redirect) v_next = '0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            err_pend      <= 1'b0;
            q             <= '0;
            v             <= '0;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= '0;
            fetch_halted  <= 1'b0;
        end else begin
            state         <= state_next;
            err_pend      <= err_pend_next;
            q             <= q_next;
            v             <= v_next;
            bus.imem_req  <= req_next;
            fetch_halted  <= halted_next;
            if (load_addr) bus.imem_addr <= pc_in;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset values, first fetch, queue-full stall,
// back-to-back throughput, redirect drain, redirect on ack, redirect flush,
// pc_err halt and reset during an outstanding request. The bench plays the
// PC bank and the instruction memory by hand.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [8:0]  pc_in;
    logic        pc_err;
    logic        redirect;
    logic        pc_inc;
    logic        fetch_halted;

    int n_checks = 0;
    int n_fail   = 0;
    int inc_cnt  = 0;
    int exp_inc  = 0;
    logic beef_seen = 1'b0;

    fetch_unit_if #(.IW(16), .AW(9)) bus ();

    fetch_unit #(.IW(16), .AW(9)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_in        (pc_in),
        .pc_err       (pc_err),
        .redirect     (redirect),
        .pc_inc       (pc_inc),
        .fetch_halted (fetch_halted),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count increment pulses and watch for discarded data reaching decode.
    always @(posedge clk) begin
        if (pc_inc) inc_cnt <= inc_cnt + 1;
        if (bus.ir_valid && bus.ir_data == 16'hBEEF) beef_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack(input logic a, input logic [15:0] d);
        bus.imem_ack  = a;
        bus.imem_data = d;
    endtask

    initial begin
        rst_n = 1'b0; pc_in = 9'h000; pc_err = 1'b0; redirect = 1'b0;
        bus.ir_ready = 1'b0;
        ack(1'b0, 16'h0000);

        // Reset values
        step(2);
        ack(1'b1, 16'h9999);
        #1;
        check("rst_pc_inc",   32'(pc_inc),        32'h0);
        check("rst_req",      32'(bus.imem_req),  32'h0);
        check("rst_addr",     32'(bus.imem_addr), 32'h0);
        check("rst_valid",    32'(bus.ir_valid),  32'h0);
        check("rst_data",     32'(bus.ir_data),   32'h0);
        check("rst_pc",       32'(bus.ir_pc),     32'h0);
        check("rst_halted",   32'(fetch_halted),  32'h0);
        ack(1'b0, 16'h0000);

        // First fetch at 0x000
        rst_n = 1'b1;
        step(1);
        check("t1_req",   32'(bus.imem_req),  32'h1);
        check("t1_addr",  32'(bus.imem_addr), 32'h000);
        check("t1_nv",    32'(bus.ir_valid),  32'h0);
        ack(1'b1, 16'h1234);
        #1;
        check("t1_inc",   32'(pc_inc), 32'h1);
        exp_inc++;
        step(1);
        check("t1_valid", 32'(bus.ir_valid),  32'h1);
        check("t1_data",  32'(bus.ir_data),   32'h1234);
        check("t1_pc",    32'(bus.ir_pc),     32'h000);
        check("t1_idle",  32'(bus.imem_req),  32'h0);
        check("t1_cnt",   32'(inc_cnt),       32'(exp_inc));
        pc_in = 9'h001;

        // Decode stalled, memory acks immediately
        ack(1'b1, 16'h5678);
`ifdef FETCH_SKID_EN
        step(1);
        check("t2_req",  32'(bus.imem_req),  32'h1);
        check("t2_addr", 32'(bus.imem_addr), 32'h001);
        exp_inc++;
        step(1);
        pc_in = 9'h002;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t2_full_noreq", 32'(bus.imem_req), 32'h0);
        end
`else
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t2_full_noreq", 32'(bus.imem_req), 32'h0);
        end
`endif
        check("t2_cnt",  32'(inc_cnt),      32'(exp_inc));
        check("t2_head", 32'(bus.ir_data),  32'h1234);
        check("t2_hpc",  32'(bus.ir_pc),    32'h000);
        ack(1'b0, 16'h0000);

        // Back-to-back fetches with decode ready
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1; pc_in = 9'h001; bus.ir_ready = 1'b1;
        check("t3_rst_nv", 32'(bus.ir_valid), 32'h0);
        step(1);
        check("t3_req1",  32'(bus.imem_req),  32'h1);
        check("t3_addr1", 32'(bus.imem_addr), 32'h001);
        ack(1'b1, 16'hA001);
        #1;
        check("t3_inc1",  32'(pc_inc), 32'h1);
        exp_inc++;
        step(1);
        ack(1'b0, 16'h0000); pc_in = 9'h002;
        check("t3_idle",  32'(bus.imem_req), 32'h0);
        check("t3_v1",    32'(bus.ir_valid), 32'h1);
        check("t3_d1",    32'(bus.ir_data),  32'hA001);
        check("t3_pc1",   32'(bus.ir_pc),    32'h001);
        step(1);
        check("t3_req2",  32'(bus.imem_req),  32'h1);
        check("t3_addr2", 32'(bus.imem_addr), 32'h002);
        check("t3_pop",   32'(bus.ir_valid),  32'h0);
        ack(1'b1, 16'hA002);
        exp_inc++;
        step(1);
        ack(1'b0, 16'h0000);
        check("t3_d2",    32'(bus.ir_data), 32'hA002);
        check("t3_pc2",   32'(bus.ir_pc),   32'h002);
        pc_in = 9'h005;

        // Redirect while waiting on memory -> drain
        step(1);
        check("t4_addr", 32'(bus.imem_addr), 32'h005);
        redirect = 1'b1; pc_in = 9'h040;
        step(1);
        redirect = 1'b0;
        check("t4_drain_req", 32'(bus.imem_req),  32'h1);
        check("t4_drain_adr", 32'(bus.imem_addr), 32'h005);
        step(1);
        ack(1'b1, 16'hDEAD);
        #1;
        check("t4_no_inc", 32'(pc_inc), 32'h0);
        step(1);
        ack(1'b0, 16'h0000);
        check("t4_idle",   32'(bus.imem_req), 32'h0);
        check("t4_nopush", 32'(bus.ir_valid), 32'h0);
        check("t4_cnt",    32'(inc_cnt),      32'(exp_inc));
        step(1);
        check("t4_req",     32'(bus.imem_req),  32'h1);
        check("t4_newaddr", 32'(bus.imem_addr), 32'h040);

        // Redirect on the ack cycle
        ack(1'b1, 16'hBEEF); redirect = 1'b1; pc_in = 9'h080;
        #1;
        check("t5_no_inc", 32'(pc_inc), 32'h0);
        step(1);
        ack(1'b0, 16'h0000); redirect = 1'b0;
        check("t5_nv",  32'(bus.ir_valid), 32'h0);
        check("t5_idle", 32'(bus.imem_req), 32'h0);
        step(1);
        check("t5_addr", 32'(bus.imem_addr), 32'h080);
        bus.ir_ready = 1'b0;
        ack(1'b1, 16'hC080);
        exp_inc++;
        step(1);
        ack(1'b0, 16'h0000);
        check("t5_v",  32'(bus.ir_valid), 32'h1);
        check("t5_pc", 32'(bus.ir_pc),    32'h080);
        check("t5_d",  32'(bus.ir_data),  32'hC080);
        // Redirect flushes a buffered entry
        redirect = 1'b1; pc_in = 9'h081;
        step(1);
        check("t5_flush", 32'(bus.ir_valid), 32'h0);
        check("t5_hold",  32'(bus.imem_req), 32'h0);
        redirect = 1'b0; pc_in = 9'h010;
        step(1);
        check("t6_req",  32'(bus.imem_req),  32'h1);
        check("t6_addr", 32'(bus.imem_addr), 32'h010);

        // pc_err during REQ: finish the fetch, then halt
        pc_err = 1'b1;
        step(1);
        pc_err = 1'b0;
        check("t6_still_req", 32'(bus.imem_req), 32'h1);
        check("t6_not_halt",  32'(fetch_halted), 32'h0);
        ack(1'b1, 16'h0F10);
        #1;
        check("t6_inc", 32'(pc_inc), 32'h1);
        exp_inc++;
        step(1);
        #1;
        check("t6_halt_noinc", 32'(pc_inc),        32'h0);
        check("t6_halted",     32'(fetch_halted),  32'h1);
        check("t6_noreq",      32'(bus.imem_req),  32'h0);
        check("t6_v",          32'(bus.ir_valid),  32'h1);
        check("t6_d",          32'(bus.ir_data),   32'h0F10);
        check("t6_pc",         32'(bus.ir_pc),     32'h010);
        bus.ir_ready = 1'b1;
        step(1);
        ack(1'b0, 16'h0000);
        check("t6_drained", 32'(bus.ir_valid), 32'h0);
        step(2);
        check("t6_stay_noreq", 32'(bus.imem_req), 32'h0);
        check("t6_stay_halt",  32'(fetch_halted), 32'h1);
        check("t6_cnt",        32'(inc_cnt),      32'(exp_inc));
        rst_n = 1'b0;
        step(1);
        check("t6_rst_clear", 32'(fetch_halted), 32'h0);

        // Reset while a request is outstanding
        rst_n = 1'b1; pc_in = 9'h020; bus.ir_ready = 1'b0;
        step(1);
        check("t7_req",  32'(bus.imem_req),  32'h1);
        check("t7_addr", 32'(bus.imem_addr), 32'h020);
        rst_n = 1'b0;
        ack(1'b1, 16'h7777);
        #1;
        check("t7_rst_noinc", 32'(pc_inc), 32'h0);
        step(1);
        rst_n = 1'b1;
        check("t7_noreq", 32'(bus.imem_req), 32'h0);
        check("t7_nv",    32'(bus.ir_valid), 32'h0);
        step(1);
        ack(1'b0, 16'h0000);
        check("t7_late_nopush", 32'(bus.ir_valid), 32'h0);
        check("t7_reissue",     32'(bus.imem_req), 32'h1);
        check("t7_cnt",         32'(inc_cnt),      32'(exp_inc));
        ack(1'b1, 16'h2020);
        exp_inc++;
        step(1);
        ack(1'b0, 16'h0000);
        check("t7_d",  32'(bus.ir_data), 32'h2020);
        check("t7_pc", 32'(bus.ir_pc),   32'h020);

        check("beef_never_seen", 32'(beef_seen), 32'h0);
        check("final_inc_cnt",   32'(inc_cnt),   32'(exp_inc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of the PC bank. Reads the active PC, runs a req/ack read on instruction memory, and buffers returned instructions for decode behind a valid/ready handshake. Pulses the PC bank's increment input exactly once per accepted fetch. Discards in-flight fetches when control redirects the PC through set, call or return.

## Interface
- `IW`, 16: instruction width in bits.
- `AW`, 9: address width; matches the PC bank output.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous reset, active-low.
- `pc_in`, in, AW: active PC from the PC bank.
- `pc_err`, in, 1: PC bank error flag (stack over/underflow).
- `redirect`, in, 1: control is asserting pc_set, pc_ref_inc or pc_ref_dec this cycle.
- `pc_inc`, out, 1: increment request to the PC bank; combinational.
- `imem_req`, out, 1: memory read request; registered.
- `imem_addr`, out, AW: memory read address; registered.
- `imem_ack`, in, 1: memory read complete; data valid this cycle.
- `imem_data`, in, IW: read data, sampled when imem_ack=1.
- `ir_valid`, out, 1: head instruction valid.
- `ir_data`, out, IW: head instruction.
- `ir_pc`, out, AW: address the head instruction was fetched from.
- `ir_ready`, in, 1: decode accepts the head this cycle.
- `fetch_halted`, out, 1: fetch stopped because of pc_err.

## Operation
- The instruction queue has depth D. D=1 by default and D=2 with FETCH_SKID_EN. Each entry holds {instr, pc}, and the outputs come from the head entry.
- Pop occurs when ir_valid && ir_ready.
- `IDLE` state:
  - pc_err=1 moves to `HALT`.
  - redirect=1 stays in `IDLE`.
  - Otherwise, if count<D, or count==D with a pop this cycle, it latches imem_addr<=pc_in and moves to `REQ`.
- `REQ` state:
  - imem_req=1 and imem_addr is held stable.
  - imem_ack=1 with redirect=0: push {imem_data, imem_addr}, pc_inc=1 this cycle, then go to `IDLE`.
  - imem_ack=1 with redirect=1: discard the data, pc_inc=0, then go to `IDLE`.
  - imem_ack=0 with redirect=1: go to `DRAIN`.
- `DRAIN` state: imem_req stays 1 because memory requests cannot be aborted. On imem_ack the data is discarded, there is no push and no pc_inc, and the FSM goes to `IDLE`.
- `HALT` state: imem_req=0, pc_inc=0, fetch_halted=1. Queued entries still drain to decode. Only rst_n=0 exits this state.
- pc_err seen while in `REQ` or `DRAIN`: the transaction completes as normal, then the FSM goes to `HALT` instead of `IDLE`.
- redirect=1 in any state empties the queue at that edge, so ir_valid=0 next cycle. A pop in the same cycle still counts as a completed handshake.
- pc_inc = (state==`REQ`) && imem_ack && !redirect. It is never asserted in any other condition.
- Push and pop in the same cycle leave count unchanged. A push never occurs when count==D unless a pop happens in the same cycle.

## Timing
- Reset values: state `IDLE`, count 0, ir_valid 0, ir_data 0, ir_pc 0, imem_req 0, imem_addr 0, fetch_halted 0. pc_inc is 0 during reset.
- First request: the first edge with rst_n=1 latches pc_in. imem_req=1 from the next cycle.
- Fetch latency: ir_valid=1 in the cycle after the imem_ack edge, with ir_pc equal to the fetch address.
- The PC bank increments on the same edge as the push, so pc_in is already incremented during the following `IDLE` cycle.
- Throughput with zero-wait memory and ir_ready=1 is one instruction every 2 cycles (`IDLE`, `REQ`).
- rst_n=0 in any state, including mid-`REQ`: all reset values apply at that edge and imem_req=0 next cycle. The outstanding ack is ignored because the FSM is in `IDLE`.

## Configuration
- `FETCH_SKID_EN` defined: D=2. Fetch continues while decode stalls, stopping after two buffered instructions.
- `FETCH_SKID_EN` undefined: D=1. A new request issues only when the queue is empty or is being popped that cycle.

## Test plan
- Reset, pc_in=0x000, memory acks 1 cycle after req with 0x1234 -> exactly one pc_inc pulse; ir_valid=1, ir_data=0x1234, ir_pc=0x000.
- ir_ready held 0, acks immediate -> D=1: no second imem_req after the first push. SKID: exactly one more req at 0x001, count=2, then imem_req stays 0.
- Request at 0x005, redirect asserted with pc_in becoming 0x040, ack arrives 3 cycles later -> `DRAIN`, no push, no pc_inc; next imem_addr=0x040.
- Redirect in the same cycle as imem_ack with data 0xBEEF -> pc_inc=0, ir_valid=0 next cycle, 0xBEEF never appears on ir_data.
- pc_err raised during `REQ` at 0x010 -> the ack pushes 0x010 with one pc_inc, then fetch_halted=1 and no further imem_req. The queued instruction is still delivered; rst_n=0 clears fetch_halted.
- rst_n=0 for one cycle while in `REQ` -> imem_req=0 and ir_valid=0 next cycle; a late ack produces no push and no pc_inc.
